// File: rtl/mem_arbiter.sv
// Round-robin arbiter that funnels NUM_PORTS requestors onto a single memory port.
// Define MEM_ARB_WATCHDOG_EN to add the BUSY-state timeout watchdog (err pulse + forced ack).
module mem_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS-1:0]        write,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  input  logic [NUM_PORTS-1:0]        extend,
  input  logic [2*NUM_PORTS-1:0]      width,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        m_req,
  output logic [ADDR_W-1:0]           m_addr,
  output logic                        m_write,
  output logic [DATA_W-1:0]           m_wdata,
  output logic                        m_extend,
  output logic [1:0]                  m_width,
  input  logic                        m_ack,
  input  logic [DATA_W-1:0]           m_rdata,
  output logic                        err
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
    $error("mem_arbiter: NUM_PORTS must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  // state | meaning
  // IDLE  | no transaction open; picks a winner whenever any req is high
  // BUSY  | latched request presented downstream, waiting for m_ack
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] win_hi;
  logic [IDX_W-1:0] win_lo;
  logic             hi_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic             sel_write;
  logic             sel_extend;
  logic [1:0]       sel_width;
  logic             busy;
  logic             wd_fire;
  logic             done;

  // Lowest requesting index at or above rr_ptr wins; otherwise wrap to the lowest below it.
  always_comb begin
    win_hi     = '0;
    win_lo     = '0;
    hi_valid   = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_write  = 1'b0;
    sel_extend = 1'b0;
    sel_width  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (IDX_W'(i) >= rr_ptr) begin
          win_hi   = IDX_W'(i);
          hi_valid = 1'b1;
        end else begin
          win_lo = IDX_W'(i);
        end
      end
    end
    winner = hi_valid ? win_hi : win_lo;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_addr   = addr[i*ADDR_W +: ADDR_W];
        sel_wdata  = wdata[i*DATA_W +: DATA_W];
        sel_write  = write[i];
        sel_extend = extend[i];
        sel_width  = width[2*i +: 2];
      end
    end
  end

  assign busy = (state == BUSY);

`ifdef MEM_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;
  // Fires in the cycle whose missing m_ack would bring the count to the limit.
  assign wd_fire = busy && !reset && !m_ack &&
                   ({1'b0, wd_cnt} + 17'd1 == 17'(TIMEOUT_CYCLES));
`else
  assign wd_fire = 1'b0;
`endif

  assign done  = busy && !reset && (m_ack || wd_fire);
  assign m_req = busy && !wd_fire;
  assign err   = wd_fire;
  assign rdata = (done && m_ack) ? m_rdata : '0;

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ack[i] = done && (grant == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      m_addr   <= '0;
      m_write  <= 1'b0;
      m_wdata  <= '0;
      m_extend <= 1'b0;
      m_width  <= '0;
`ifdef MEM_ARB_WATCHDOG_EN
      wd_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= winner;
            m_addr   <= sel_addr;
            m_write  <= sel_write;
            m_wdata  <= sel_wdata;
            m_extend <= sel_extend;
            m_width  <= sel_width;
            state    <= BUSY;
`ifdef MEM_ARB_WATCHDOG_EN
            wd_cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          if (done) begin
            state  <= IDLE;
            rr_ptr <= (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
          end
`ifdef MEM_ARB_WATCHDOG_EN
          else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (3 ports): directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  localparam logic [31:0] A0 = 32'h0000_00A0;
  localparam logic [31:0] A1 = 32'h0000_0100;
  localparam logic [31:0] A2 = 32'h0000_02C0;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     req, write, extend;
  logic [2*NP-1:0]   width;
  logic [AW-1:0]     p_addr[NP];
  logic [DW-1:0]     p_wdata[NP];
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wdata;
  logic [NP-1:0]     ack;
  logic [DW-1:0]     rdata;
  logic              m_req, m_write, m_extend, m_ack, err;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata, m_rdata;
  logic [1:0]        m_width;

  assign addr  = {p_addr[2], p_addr[1], p_addr[0]};
  assign wdata = {p_wdata[2], p_wdata[1], p_wdata[0]};

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .write(write), .wdata(wdata),
    .extend(extend), .width(width), .ack(ack), .rdata(rdata), .m_req(m_req),
    .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata), .m_extend(m_extend),
    .m_width(m_width), .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        mack;
    logic [31:0] mrd;
    logic        e_mreq;
    logic [31:0] e_addr;
    logic [2:0]  e_ack;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [2:0] rq, logic mk_ack, logic [31:0] mrd,
                              logic e_mreq, logic [31:0] e_addr, logic [2:0] e_ack,
                              logic [31:0] e_rdata);
    vec_t v;
    v.rst = rst; v.req = rq; v.mack = mk_ack; v.mrd = mrd;
    v.e_mreq = e_mreq; v.e_addr = e_addr; v.e_ack = e_ack; v.e_rdata = e_rdata;
    return v;
  endfunction

  vec_t tbl[$];

  task automatic set_defaults();
    p_addr[0] = A0; p_addr[1] = A1; p_addr[2] = A2;
    for (int i = 0; i < NP; i++) p_wdata[i] = 32'h1000 + i;
    write = '0; extend = '0; width = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; m_ack = 1'b0; m_rdata = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2:0]  pend;
    logic        mbusy, fire, done;
    int          mg, mrr, mwait, got;
    logic [31:0] la, lw;
    logic        lwr, lex;
    logic [1:0]  lwd;
    logic [2:0]  exp_ack;

    set_defaults();
    do_reset();

    // Reset state
    #2;
    chk("rst_m_req", m_req, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);

    // Directed table: single request, m_ack ignored in IDLE, wrap, reset mid-BUSY
    tbl.push_back(mk(0, 3'b010, 0, 32'h0,        0, 0,  3'b000, 0));
    tbl.push_back(mk(0, 3'b010, 0, 32'h0,        1, A1, 3'b000, 0));
    tbl.push_back(mk(0, 3'b010, 1, 32'hDEAD_BEEF,1, A1, 3'b010, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, 3'b000, 1, 32'h1234,     0, 0,  3'b000, 0));
    tbl.push_back(mk(0, 3'b011, 0, 32'h0,        0, 0,  3'b000, 0));
    tbl.push_back(mk(0, 3'b011, 1, 32'hA5,       1, A0, 3'b001, 32'hA5));
    tbl.push_back(mk(0, 3'b010, 0, 32'h0,        0, 0,  3'b000, 0));
    tbl.push_back(mk(0, 3'b010, 1, 32'h77,       1, A1, 3'b010, 32'h77));
    tbl.push_back(mk(0, 3'b100, 0, 32'h0,        0, 0,  3'b000, 0));
    tbl.push_back(mk(0, 3'b100, 0, 32'h0,        1, A2, 3'b000, 0));
    tbl.push_back(mk(0, 3'b100, 0, 32'h0,        1, A2, 3'b000, 0));
    tbl.push_back(mk(1, 3'b100, 0, 32'h0,        1, A2, 3'b000, 0));
    tbl.push_back(mk(0, 3'b101, 0, 32'h0,        0, 0,  3'b000, 0));
    tbl.push_back(mk(0, 3'b101, 1, 32'hCAFE,     1, A0, 3'b001, 32'hCAFE));
    tbl.push_back(mk(0, 3'b100, 0, 32'h0,        0, 0,  3'b000, 0));
    tbl.push_back(mk(0, 3'b100, 1, 32'h5,        1, A2, 3'b100, 32'h5));
    tbl.push_back(mk(0, 3'b000, 0, 32'h0,        0, 0,  3'b000, 0));

    foreach (tbl[n]) begin
      reset = tbl[n].rst; req = tbl[n].req; m_ack = tbl[n].mack; m_rdata = tbl[n].mrd;
      #2;
      chk($sformatf("tbl%0d_m_req", n), m_req, tbl[n].e_mreq);
      chk($sformatf("tbl%0d_ack", n), ack, tbl[n].e_ack);
      chk($sformatf("tbl%0d_rdata", n), rdata, tbl[n].e_rdata);
      chk($sformatf("tbl%0d_err", n), err, 0);
      if (tbl[n].e_mreq) chk($sformatf("tbl%0d_m_addr", n), m_addr, tbl[n].e_addr);
      cycle();
    end
    reset = 1'b0;

    // Fairness: all ports requesting, m_ack always high
    do_reset();
    req = 3'b111; m_ack = 1'b1; m_rdata = 32'h55;
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      #2;
      if (ack != 0) begin
        for (int i = 0; i < NP; i++)
          if (ack[i]) chk($sformatf("fair_order%0d", got), i, got % NP);
        got++;
      end
      cycle();
    end
    chk("fair_count", got, 6);
    req = '0; m_ack = 1'b0;
    cycle();

    // Payload stability while BUSY (rr_ptr back at 0)
    p_addr[0] = 32'h1111_0000; p_wdata[0] = 32'hAAAA_5555;
    write = 3'b001; extend = 3'b001; width = 6'b00_00_10;
    req = 3'b001;
    cycle();
    p_addr[0] = 32'hFFFF_FFFF; p_wdata[0] = 32'h0; write = '0; extend = '0; width = '0;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("stab_m_req", m_req, 1);
      chk("stab_m_addr", m_addr, 32'h1111_0000);
      chk("stab_m_wdata", m_wdata, 32'hAAAA_5555);
      chk("stab_m_write", m_write, 1);
      chk("stab_m_extend", m_extend, 1);
      chk("stab_m_width", m_width, 2);
      cycle();
    end
    m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
    #2;
    chk("stab_ack", ack, 3'b001);
    chk("stab_rdata", rdata, 32'h0BAD_F00D);
    cycle();
    m_ack = 1'b0; req = '0;
    set_defaults();
    cycle();

    // Downstream never answers: watchdog timeout, or indefinite wait without it
    req = 3'b010; m_rdata = 32'h1357_9BDF;
    cycle();
`ifdef MEM_ARB_WATCHDOG_EN
    for (int b = 1; b <= TO; b++) begin
      #2;
      if (b < TO) begin
        chk("wd_wait_err", err, 0);
        chk("wd_wait_ack", ack, 0);
        chk("wd_wait_m_req", m_req, 1);
      end else begin
        chk("wd_err", err, 1);
        chk("wd_ack", ack, 3'b010);
        chk("wd_rdata", rdata, 0);
        chk("wd_m_req", m_req, 0);
      end
      cycle();
    end
    req = '0;
    #2;
    chk("wd_after_m_req", m_req, 0);
    chk("wd_after_err", err, 0);
    cycle();
`else
    for (int b = 0; b < 10; b++) begin
      #2;
      chk("nowd_m_req", m_req, 1);
      chk("nowd_err", err, 0);
      chk("nowd_ack", ack, 0);
      cycle();
    end
    m_ack = 1'b1;
    #2;
    chk("nowd_ack_final", ack, 3'b010);
    chk("nowd_rdata", rdata, 32'h1357_9BDF);
    cycle();
    m_ack = 1'b0; req = '0;
`endif

    // Randomized traffic vs transaction-level model
    do_reset();
    pend = '0; mbusy = 1'b0; mg = 0; mrr = 0; mwait = 0;
    la = '0; lw = '0; lwr = 1'b0; lex = 1'b0; lwd = '0;
    for (int c = 0; c < 400; c++) begin
      pend = pend | (3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
      req = pend;
      for (int i = 0; i < NP; i++) begin
        p_addr[i] = $urandom; p_wdata[i] = $urandom;
        width[2*i +: 2] = 2'($urandom_range(0, 2));
      end
      write = 3'($urandom_range(0, 7)); extend = 3'($urandom_range(0, 7));
      m_ack = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      #2;
      fire = 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
      fire = mbusy && !m_ack && (mwait + 1 == TO);
`endif
      done = mbusy && (m_ack || fire);
      exp_ack = done ? 3'(1 << mg) : 3'b000;
      chk("rnd_m_req", m_req, mbusy && !fire);
      chk("rnd_ack", ack, exp_ack);
      chk("rnd_rdata", rdata, (mbusy && m_ack) ? m_rdata : 32'h0);
      chk("rnd_err", err, fire);
      chk("rnd_ack_onehot", ($countones(ack) <= 1), 1);
      if (mbusy) begin
        chk("rnd_m_addr", m_addr, la);
        chk("rnd_m_wdata", m_wdata, lw);
        chk("rnd_m_write", m_write, lwr);
        chk("rnd_m_extend", m_extend, lex);
        chk("rnd_m_width", m_width, lwd);
      end
      if (done) begin
        pend[mg] = 1'b0;
        mbusy = 1'b0;
        mrr = (mg + 1) % NP;
      end else if (mbusy) begin
        mwait++;
      end else if (pend != 0) begin
        for (int k = NP - 1; k >= 0; k--)
          if (pend[(mrr + k) % NP]) mg = (mrr + k) % NP;
        la = p_addr[mg]; lw = p_wdata[mg]; lwr = write[mg]; lex = extend[mg];
        lwd = width[2*mg +: 2];
        mbusy = 1'b1; mwait = 0;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requestor ports (2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles (1..65535).
REQ-005 Port clk  input  1  sole clock; every register updates on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port req  input  NUM_PORTS  per-port request; held high until that port's ack.
REQ-008 Port addr  input  NUM_PORTS*ADDR_W  per-port address; port i at slice [i*ADDR_W +: ADDR_W].
REQ-009 Port write  input  NUM_PORTS  per-port write flag.
REQ-010 Port wdata  input  NUM_PORTS*DATA_W  per-port write data.
REQ-011 Port extend  input  NUM_PORTS  per-port sign-extend flag.
REQ-012 Port width  input  2*NUM_PORTS  per-port access width code (0 byte, 1 half, 2 word).
REQ-013 Port ack  output  NUM_PORTS  per-port one-cycle completion pulse.
REQ-014 Port rdata  output  DATA_W  read data, shared by all ports, valid only when an ack bit is high.
REQ-015 Port m_req, m_addr, m_write, m_wdata, m_extend, m_width  output  1/ADDR_W/1/DATA_W/1/2  downstream request and its payload.
REQ-016 Port m_ack  input  1  downstream completion; m_rdata  input  DATA_W  downstream read data.
REQ-017 Port err  output  1  one-cycle watchdog timeout pulse.

Function
REQ-018 The FSM SHALL have two states, IDLE and BUSY.
REQ-019 In IDLE, when any req bit is high, the arbiter SHALL select a winner, latch its index and full payload into registers, and enter BUSY on the next edge.
REQ-020 The winner SHALL be the first requesting port at or after rr_ptr, searching upward with wrap from NUM_PORTS-1 to 0.
REQ-021 In BUSY, m_req SHALL be 1 and m_* SHALL come from the latched registers, so they remain stable regardless of requestor inputs.
REQ-022 In BUSY with m_ack=1, ack[grant] SHALL be 1 and rdata SHALL equal m_rdata in that same cycle; the FSM SHALL then return to IDLE and set rr_ptr to (grant+1) mod NUM_PORTS.
REQ-023 Exactly one ack bit SHALL be high in any cycle, or none.
REQ-024 The arbiter SHALL spend at least one IDLE cycle between transactions, giving a minimum of two cycles per transaction (IDLE grant, BUSY with m_ack).
REQ-025 The arbiter SHALL ignore m_ack while in IDLE.
REQ-026 If a requestor drops req while BUSY, the transaction SHALL still complete and ack SHALL still be pulsed; dropping req is a protocol violation that the block does not check.
REQ-027 Requests that arrive while BUSY SHALL wait and SHALL NOT be lost.

Reset
REQ-028 While reset is high at an edge, the arbiter SHALL set: state=IDLE, rr_ptr=0, ack=0, err=0, m_req=0, all latched payload=0, and watchdog count=0.
REQ-029 Reset asserted mid-BUSY SHALL abort the transaction without an ack; the arbiter SHALL accept requests on the first edge after reset deasserts.
REQ-030 rdata SHALL be 0 whenever no ack bit is high.

Configuration
REQ-031 With macro MEM_ARB_WATCHDOG_EN defined, a 16-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle with m_ack=0.
REQ-032 With MEM_ARB_WATCHDOG_EN defined, when the count reaches TIMEOUT_CYCLES the arbiter SHALL, in that cycle, pulse err=1 and ack[grant]=1 with rdata=0, drop m_req, return to IDLE, and advance rr_ptr.
REQ-033 With MEM_ARB_WATCHDOG_EN undefined, err SHALL be tied 0, no counter SHALL exist, and BUSY SHALL wait for m_ack indefinitely.

Verification (NUM_PORTS=3)
REQ-034 Single request: req=3'b010, addr1=0x100, m_ack one cycle after m_req -> m_addr=0x100, ack=3'b010 exactly once, rdata=m_rdata.
REQ-035 Fairness: req=3'b111 held (each port re-raises req after its ack), m_ack returned immediately -> grants in order 0,1,2,0,1,2 with no port granted twice in a row.
REQ-036 Wrap: rr_ptr=2, req=3'b011 -> port 0 granted first, then port 1.
REQ-037 Reset mid-BUSY: reset pulsed two cycles after m_req rises -> no ack; next request is granted starting from port 0.
REQ-038 Watchdog with macro defined and TIMEOUT_CYCLES=4: m_ack never asserted -> err=1 and ack[grant]=1 with rdata=0 on the 4th BUSY cycle without m_ack.
REQ-039 Payload stability: requestor changes addr and wdata while BUSY -> m_addr and m_wdata remain at the values latched at grant.
